// File: rtl/mux21_2b_rr_sched_if.sv
// Producer/consumer bundle for the round-robin scheduler: two push ports,
// one registered output port with valid/ready, plus FIFO status flags.
interface mux21_2b_rr_sched_if #(
    parameter int BW = 2
);
    // Push side: inX_valid is a strobe with no ready; a push into a full FIFO
    // is dropped and flagged on ovfX. Output side: a word transfers on every
    // posedge where out_valid && out_ready; while out_valid && !out_ready,
    // out_data/out_src/out_valid are held stable.
    logic [BW-1:0] in0;
    logic          in0_valid;
    logic [BW-1:0] in1;
    logic          in1_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_src;
    logic          fifo0_full;
    logic          fifo1_full;
    logic          fifo0_empty;
    logic          fifo1_empty;
    logic          ovf0;
    logic          ovf1;

    modport master (
        output in0, in0_valid, in1, in1_valid, out_ready,
        input  out_data, out_valid, out_src,
               fifo0_full, fifo1_full, fifo0_empty, fifo1_empty, ovf0, ovf1
    );

    modport slave (
        input  in0, in0_valid, in1, in1_valid, out_ready,
        output out_data, out_valid, out_src,
               fifo0_full, fifo1_full, fifo0_empty, fifo1_empty, ovf0, ovf1
    );
endinterface

// File: rtl/mux21_2b_rr_sched.sv
// Two input FIFOs feeding one registered output stage; a round-robin grant
// drives the 2:1 select so both requesters share the output fairly.
module mux21_2b_rr_sched #(
    parameter int BW    = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic               clk,
    input logic               reset,
    mux21_2b_rr_sched_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [BW-1:0] mem0 [DEPTH];
    logic [BW-1:0] mem1 [DEPTH];
    logic [AW-1:0] wr0, rd0, wr1, rd1;
    logic [AW:0]   cnt0, cnt1;
    logic          last_grant;
    logic [BW-1:0] out_data_q;
    logic          out_valid_q;
    logic          out_src_q;
    logic          ovf0_q, ovf1_q;

    logic          full0, full1, empty0, empty1;
    logic          push0, push1, pop0, pop1;
    logic          stage_free;
    logic          grant_vld, grant;
    logic [BW-1:0] head;

    assign full0      = (cnt0 == FULL_CNT);
    assign full1      = (cnt1 == FULL_CNT);
    assign empty0     = (cnt0 == '0);
    assign empty1     = (cnt1 == '0);
    assign push0      = bus.in0_valid && !full0;
    assign push1      = bus.in1_valid && !full1;
    assign stage_free = !out_valid_q || bus.out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (stage_free) begin
            if (!empty0 && !empty1) begin
                grant_vld = 1'b1;
                grant     = ~last_grant;
            end else if (!empty0) begin
                grant_vld = 1'b1;
                grant     = 1'b0;
            end else if (!empty1) begin
                grant_vld = 1'b1;
                grant     = 1'b1;
            end
        end
    end

    assign pop0 = grant_vld && !grant;
    assign pop1 = grant_vld && grant;
    // The shared 2:1 datapath: grant is the select.
    assign head = grant ? mem1[rd1] : mem0[rd0];

    // Storage needs no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push0) mem0[wr0] <= bus.in0;
        if (!reset && push1) mem1[wr1] <= bus.in1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr0    <= '0;
            rd0    <= '0;
            cnt0   <= '0;
            wr1    <= '0;
            rd1    <= '0;
            cnt1   <= '0;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
        end else begin
            if (push0) wr0 <= wr0 + AW'(1);
            if (pop0)  rd0 <= rd0 + AW'(1);
            if (push1) wr1 <= wr1 + AW'(1);
            if (pop1)  rd1 <= rd1 + AW'(1);
            cnt0 <= cnt0 + {{AW{1'b0}}, push0} - {{AW{1'b0}}, pop0};
            cnt1 <= cnt1 + {{AW{1'b0}}, push1} - {{AW{1'b0}}, pop1};
            if (bus.in0_valid && full0) ovf0_q <= 1'b1;
            if (bus.in1_valid && full1) ovf1_q <= 1'b1;
        end
    end

    // last_grant resets to 1 so in0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            last_grant  <= 1'b1;
        end else if (grant_vld) begin
            out_data_q  <= head;
            out_src_q   <= grant;
            out_valid_q <= 1'b1;
            last_grant  <= grant;
        end else if (stage_free) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_src     = out_src_q;
    assign bus.fifo0_full  = full0;
    assign bus.fifo1_full  = full1;
    assign bus.fifo0_empty = empty0;
    assign bus.fifo1_empty = empty1;
    assign bus.ovf0        = ovf0_q;
    assign bus.ovf1        = ovf1_q;
endmodule

// File: tb/tb_mux21_2b_rr_sched.sv
// Bench for mux21_2b_rr_sched: directed scenarios plus a random phase, with
// per-source expected queues checked at every output handshake.
module tb_mux21_2b_rr_sched;
    localparam int BW    = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;
    int   out_cnt0, out_cnt1;
    logic [BW-1:0] exp_q0[$];
    logic [BW-1:0] exp_q1[$];
    logic [2:0]    t3 [8];
    logic [BW-1:0] w4 [6];

    mux21_2b_rr_sched_if #(.BW(BW)) bus ();

    mux21_2b_rr_sched #(.BW(BW), .DEPTH(DEPTH), .AW(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard pop at the pre-edge handshake, then advance one clock.
    task automatic cycle();
        logic [BW-1:0] e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (bus.out_src == 1'b0) begin
                check("sb_q0_pending", exp_q0.size() > 0, 1);
                if (exp_q0.size() > 0) begin
                    e = exp_q0.pop_front();
                    check("sb_q0_data", bus.out_data, e);
                    out_cnt0--;
                end
            end else begin
                check("sb_q1_pending", exp_q1.size() > 0, 1);
                if (exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    check("sb_q1_data", bus.out_data, e);
                    out_cnt1--;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic push(input int src, input logic [BW-1:0] d, input bit accept);
        if (src == 0) begin
            bus.in0 = d;
            bus.in0_valid = 1'b1;
            if (accept) begin
                exp_q0.push_back(d);
                out_cnt0++;
            end
        end else begin
            bus.in1 = d;
            bus.in1_valid = 1'b1;
            if (accept) begin
                exp_q1.push_back(d);
                out_cnt1++;
            end
        end
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        out_cnt0 = 0;
        out_cnt1 = 0;
    endtask

    task automatic reset_dut();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && !bus.out_valid) break;
            cycle();
        end
        check("drain_q0_empty", exp_q0.size(), 0);
        check("drain_q1_empty", exp_q1.size(), 0);
        check("drain_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        n_checks = 0;
        n_err = 0;
        reset = 1'b1;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b0;
        clear_model();
        // {src, data} expected after the full-FIFO release
        t3[0] = 3'b000; t3[1] = 3'b111; t3[2] = 3'b001; t3[3] = 3'b110;
        t3[4] = 3'b010; t3[5] = 3'b101; t3[6] = 3'b011; t3[7] = 3'b100;
        w4[0] = 2'b01; w4[1] = 2'b10; w4[2] = 2'b11;
        w4[3] = 2'b00; w4[4] = 2'b01; w4[5] = 2'b10;

        // 1: reset with push strobes high
        for (int i = 0; i < 2; i++) begin
            push(0, 2'b11, 1'b0);
            push(1, 2'b10, 1'b0);
            cycle();
        end
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_src", bus.out_src, 0);
        check("rst_empty0", bus.fifo0_empty, 1);
        check("rst_empty1", bus.fifo1_empty, 1);
        check("rst_full0", bus.fifo0_full, 0);
        check("rst_full1", bus.fifo1_full, 0);
        check("rst_ovf0", bus.ovf0, 0);
        check("rst_ovf1", bus.ovf1, 0);
        reset = 1'b0;
        cycle();
        check("rst_no_push0", bus.fifo0_empty, 1);
        check("rst_no_push1", bus.fifo1_empty, 1);

        // 2: single word latency
        bus.out_ready = 1'b1;
        push(0, 2'b01, 1'b1);
        cycle();
        check("lat_in_fifo", bus.fifo0_empty, 0);
        check("lat_not_yet", bus.out_valid, 0);
        cycle();
        check("lat_valid", bus.out_valid, 1);
        check("lat_data", bus.out_data, 2'b01);
        check("lat_src", bus.out_src, 0);
        check("lat_fifo_popped", bus.fifo0_empty, 1);
        cycle();
        check("lat_valid_drop", bus.out_valid, 0);

        // 3: fill both under backpressure, then release
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            push(0, BW'(i), 1'b1);
            push(1, BW'(3 - i), 1'b1);
            cycle();
        end
        check("fill_out_valid", bus.out_valid, 1);
        check("fill_out_data", bus.out_data, 2'b00);
        check("fill_out_src", bus.out_src, 0);
        check("fill_full1", bus.fifo1_full, 1);
        check("fill_full0", bus.fifo0_full, 0);
        check("fill_empty0", bus.fifo0_empty, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("rr_valid", bus.out_valid, 1);
            check("rr_data", bus.out_data, t3[i][1:0]);
            check("rr_src", bus.out_src, t3[i][2]);
            cycle();
        end
        check("rr_done", bus.out_valid, 0);

        // 4: overflow on in1
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            push(1, w4[i], i < 5);
            cycle();
            if (i == 4) begin
                check("ovf_full_at5", bus.fifo1_full, 1);
                check("ovf_clear_at5", bus.ovf1, 0);
            end
            if (i == 5) check("ovf_set", bus.ovf1, 1);
        end
        bus.out_ready = 1'b1;
        drain(40);
        check("ovf_sticky", bus.ovf1, 1);
        check("ovf0_clean", bus.ovf0, 0);

        // 5: backpressure hold
        reset_dut();
        push(0, 2'b10, 1'b1);
        cycle();
        push(0, 2'b01, 1'b1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            check("bp_data", bus.out_data, 2'b10);
            check("bp_src", bus.out_src, 0);
            check("bp_valid", bus.out_valid, 1);
            check("bp_no_pop", bus.fifo0_empty, 0);
            cycle();
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_next_data", bus.out_data, 2'b01);
        check("bp_one_pop", bus.fifo0_empty, 1);
        drain(10);

        // 6: reset mid-operation discards everything
        reset_dut();
        push(0, 2'b01, 1'b1); push(1, 2'b10, 1'b1); cycle();
        push(0, 2'b11, 1'b1); push(1, 2'b00, 1'b1); cycle();
        push(0, 2'b10, 1'b1); cycle();
        check("mid_valid", bus.out_valid, 1);
        check("mid_empty0", bus.fifo0_empty, 0);
        check("mid_empty1", bus.fifo1_empty, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_model();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_empty0", bus.fifo0_empty, 1);
        check("mid_rst_empty1", bus.fifo1_empty, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("mid_quiet", bus.out_valid, 0);
        end

        // random traffic that never overfills a FIFO
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && out_cnt0 < DEPTH) push(0, BW'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 1) == 1 && out_cnt1 < DEPTH) push(1, BW'($urandom_range(0, 3)), 1'b1);
            cycle();
        end
        bus.out_ready = 1'b1;
        drain(60);
        check("rnd_ovf0", bus.ovf0, 0);
        check("rnd_ovf1", bus.ovf1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
